// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the multi-cycle stage sequencer.
// Stage encodings are visible on the Stage output and must stay fixed.
package stage_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IF    = 3'd0,
      ST_ID    = 3'd1,
      ST_EX    = 3'd2,
      ST_MEM   = 3'd3,
      ST_WB    = 3'd4,
      ST_HALT  = 3'd5,
      ST_FAULT = 3'd6
   } stage_e;

   localparam int CNT_W           = 64;
   localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Clearable wait counter with timeout compare for memory handshakes.
// LIMIT of 0 disables the timeout; expired is combinational.
module wait_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   output logic expired
);

   localparam int W  = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam bit EN = (LIMIT > 0);
   localparam logic [W-1:0] LAST = W'((LIMIT > 0) ? LIMIT - 1 : 0);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (EN && waiting && cnt != LAST) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Expires in the LIMIT-th unacknowledged cycle; an ack drops waiting.
   assign expired = EN && waiting && (cnt == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control FSM for the sequential RV64 core: IF/ID/EX/MEM/WB
// sequencing, memory handshakes, write gating, counters and timeout.
module stage_sequencer
   import stage_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             IMemAck,
   input  logic             DMemAck,
   input  logic             MemRead,
   input  logic             MemWrite,
   input  logic             RegWrite,
   input  logic             Halt,
   output logic             IMemReq,
   output logic             DMemReq,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWriteEn,
   output logic [2:0]       Stage,
   output logic             Halted,
   output logic             Fault,
   output logic [CNT_W-1:0] CycleCount,
   output logic [CNT_W-1:0] InstRet
);

   stage_e state_q;
   stage_e state_d;

   logic imreq;
   logic dmreq;
   logic irw;
   logic pcw;
   logic rwe;
   logic waiting;
   logic expired;
   logic clear;

   always_comb begin
      waiting = 1'b0;
      if (state_q == ST_IF)  waiting = !IMemAck;
      if (state_q == ST_MEM) waiting = !DMemAck;
   end

   always_comb begin
      state_d = state_q;
      imreq   = 1'b0;
      dmreq   = 1'b0;
      irw     = 1'b0;
      pcw     = 1'b0;
      rwe     = 1'b0;
      unique case (state_q)
         ST_IF: begin
            imreq = 1'b1;
            if (IMemAck) begin
               irw     = 1'b1;
               state_d = ST_ID;
            end else if (expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_ID: begin
            state_d = Halt ? ST_HALT : ST_EX;
         end
         ST_EX: begin
            if (MemRead || MemWrite) begin
               state_d = ST_MEM;
            end else if (RegWrite) begin
               state_d = ST_WB;
            end else begin
               pcw     = 1'b1;
               state_d = ST_IF;
            end
         end
         ST_MEM: begin
            dmreq = 1'b1;
            if (DMemAck) begin
               if (MemRead && RegWrite) begin
                  state_d = ST_WB;
               end else begin
                  pcw     = 1'b1;
                  state_d = ST_IF;
               end
            end else if (expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_WB: begin
            rwe     = 1'b1;
            pcw     = 1'b1;
            state_d = ST_IF;
         end
         ST_HALT, ST_FAULT: begin
            state_d = state_q;
         end
         default: begin
            state_d = ST_IF;
         end
      endcase
   end

   // Any state change restarts the wait count, covering entry to IF and MEM.
   assign clear = (state_d != state_q);

   wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_wait (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .waiting (waiting),
      .expired (expired)
   );

   // Strobes drop with reset so an aborted request is released at once.
   assign IMemReq    = rst_n & imreq;
   assign DMemReq    = rst_n & dmreq;
   assign IRWrite    = rst_n & irw;
   assign PCWrite    = rst_n & pcw;
   assign RegWriteEn = rst_n & rwe;
   assign Stage      = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IF;
         Halted     <= 1'b0;
         Fault      <= 1'b0;
         CycleCount <= '0;
         InstRet    <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == ST_HALT)  Halted <= 1'b1;
         if (state_d == ST_FAULT) Fault  <= 1'b1;
         if (state_q != ST_HALT && state_q != ST_FAULT) begin
            CycleCount <= CycleCount + 1'b1;
         end
         if (pcw) begin
            InstRet <= InstRet + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with MEM_TIMEOUT=4.
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
module tb_stage_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        IMemAck;
   logic        DMemAck;
   logic        MemRead;
   logic        MemWrite;
   logic        RegWrite;
   logic        Halt;
   logic        IMemReq;
   logic        DMemReq;
   logic        IRWrite;
   logic        PCWrite;
   logic        RegWriteEn;
   logic [2:0]  Stage;
   logic        Halted;
   logic        Fault;
   logic [63:0] CycleCount;
   logic [63:0] InstRet;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   stage_sequencer #(
      .MEM_TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .IMemAck    (IMemAck),
      .DMemAck    (DMemAck),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .RegWrite   (RegWrite),
      .Halt       (Halt),
      .IMemReq    (IMemReq),
      .DMemReq    (DMemReq),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWriteEn (RegWriteEn),
      .Stage      (Stage),
      .Halted     (Halted),
      .Fault      (Fault),
      .CycleCount (CycleCount),
      .InstRet    (InstRet)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] outs();
      return {59'd0, IMemReq, DMemReq, IRWrite, PCWrite, RegWriteEn};
   endfunction

   task automatic set_dec(input logic [3:0] d);
      {MemRead, MemWrite, RegWrite, Halt} = d;
   endtask

   // One cycle: drive acks, check Stage and {IMemReq,DMemReq,IRWrite,PCWrite,RegWriteEn}.
   task automatic cyc(input string tag, input logic ia, input logic da,
                      input logic [2:0] st, input logic [4:0] o);
      IMemAck = ia;
      DMemAck = da;
      #1;
      chk({tag, ".stage"}, {61'd0, Stage}, {61'd0, st});
      chk({tag, ".out"}, outs(), {59'd0, o});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      IMemAck = 1'b0;
      DMemAck = 1'b0;
      set_dec(4'b0000);
      @(posedge clk);
      #1;
      chk("rst.stage", {61'd0, Stage}, 64'd0);
      chk("rst.out", outs(), 64'd0);
      chk("rst.cc", CycleCount, 64'd0);
      chk("rst.ir", InstRet, 64'd0);
      chk("rst.flags", {62'd0, Halted, Fault}, 64'd0);
      rst_n = 1'b1;

      // ALU op
      set_dec(4'b0010);
      cyc("alu.if", 1, 0, 3'd0, 5'b10100);
      cyc("alu.id", 0, 0, 3'd1, 5'b00000);
      cyc("alu.ex", 0, 0, 3'd2, 5'b00000);
      cyc("alu.wb", 0, 0, 3'd4, 5'b00011);
      chk("alu.cc", CycleCount, 64'd4);
      chk("alu.ir", InstRet, 64'd1);

      // Load, DMemAck in the 4th (last allowed) MEM cycle
      set_dec(4'b1010);
      cyc("ld.if", 1, 0, 3'd0, 5'b10100);
      cyc("ld.id", 0, 0, 3'd1, 5'b00000);
      cyc("ld.ex", 0, 0, 3'd2, 5'b00000);
      for (int i = 0; i < 3; i++) cyc("ld.mw", 0, 0, 3'd3, 5'b01000);
      cyc("ld.mack", 0, 1, 3'd3, 5'b01000);
      cyc("ld.wb", 0, 0, 3'd4, 5'b00011);
      chk("ld.cc", CycleCount, 64'd12);
      chk("ld.ir", InstRet, 64'd2);

      // Store
      set_dec(4'b0100);
      cyc("st.if", 1, 0, 3'd0, 5'b10100);
      cyc("st.id", 0, 0, 3'd1, 5'b00000);
      cyc("st.ex", 0, 0, 3'd2, 5'b00000);
      cyc("st.mem", 0, 1, 3'd3, 5'b01010);
      chk("st.cc", CycleCount, 64'd16);
      chk("st.ir", InstRet, 64'd3);

      // Branch, with stray acks in ID
      set_dec(4'b0000);
      cyc("br.if", 1, 0, 3'd0, 5'b10100);
      cyc("br.id", 1, 1, 3'd1, 5'b00000);
      cyc("br.ex", 0, 0, 3'd2, 5'b00010);
      chk("br.cc", CycleCount, 64'd19);
      chk("br.ir", InstRet, 64'd4);

      // Halt
      set_dec(4'b0001);
      cyc("hl.if", 1, 0, 3'd0, 5'b10100);
      cyc("hl.id", 0, 0, 3'd1, 5'b00000);
      for (int i = 0; i < 100; i++) cyc("hl.halt", 1, 1, 3'd5, 5'b00000);
      chk("hl.halted", {63'd0, Halted}, 64'd1);
      chk("hl.fault", {63'd0, Fault}, 64'd0);
      chk("hl.cc", CycleCount, 64'd21);
      chk("hl.ir", InstRet, 64'd4);

      // Reset from HALT, then fetch timeout
      rst_n = 1'b0;
      #1;
      chk("r1.stage", {61'd0, Stage}, 64'd0);
      chk("r1.halted", {63'd0, Halted}, 64'd0);
      chk("r1.cc", CycleCount, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_dec(4'b0000);
      for (int i = 0; i < 4; i++) cyc("to.if", 0, 0, 3'd0, 5'b10000);
      chk("to.fault", {63'd0, Fault}, 64'd1);
      for (int i = 0; i < 5; i++) cyc("to.flt", 1, 1, 3'd6, 5'b00000);
      chk("to.cc", CycleCount, 64'd4);
      chk("to.ir", InstRet, 64'd0);
      chk("to.fault2", {63'd0, Fault}, 64'd1);

      // Reset during MEM of a load
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_dec(4'b1010);
      cyc("rm.if", 1, 0, 3'd0, 5'b10100);
      cyc("rm.id", 0, 0, 3'd1, 5'b00000);
      cyc("rm.ex", 0, 0, 3'd2, 5'b00000);
      cyc("rm.mw", 0, 0, 3'd3, 5'b01000);
      rst_n = 1'b0;
      #1;
      chk("rm.out", outs(), 64'd0);
      chk("rm.stage", {61'd0, Stage}, 64'd0);
      chk("rm.cc", CycleCount, 64'd0);
      chk("rm.ir", InstRet, 64'd0);
      chk("rm.fault", {63'd0, Fault}, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      IMemAck = 1'b0;
      DMemAck = 1'b0;
      #1;
      chk("rm.imreq", {63'd0, IMemReq}, 64'd1);
      chk("rm.stage2", {61'd0, Stage}, 64'd0);
      chk("rm.dmreq", {63'd0, DMemReq}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control FSM for the sequential RV64 core. Steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with instruction and data memory. Gates the register-file write enable fed to the writeback stage and the PC/IR update strobes. Keeps 64-bit cycle and retired-instruction counters and detects memory timeouts.

## Interface
- MEM_TIMEOUT, default 16: maximum cycles a memory request may stay unacknowledged; 0 disables the timeout.

- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- IMemAck  input  1  instruction memory has returned the fetch word this cycle
- DMemAck  input  1  data memory has completed the load or store this cycle
- MemRead  input  1  decoded load (from the control decoder; stable from ID onward)
- MemWrite  input  1  decoded store
- RegWrite  input  1  decoded instruction writes rd
- Halt  input  1  decoded ecall/ebreak; sampled in ID only
- IMemReq  output  1  fetch request
- DMemReq  output  1  data memory request
- IRWrite  output  1  latch the fetched instruction
- PCWrite  output  1  commit next PC; one pulse per retired instruction
- RegWriteEn  output  1  register-file write enable to writeback
- Stage  output  3  current state encoding
- Halted  output  1  sticky halt
- Fault  output  1  sticky memory timeout
- CycleCount  output  64  cycles executed
- InstRet  output  64  instructions retired

## Operation
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, FAULT=6.
- Reset:
  - State goes to IF; the wait counter clears.
  - CycleCount and InstRet go to 0; Halted and Fault go to 0.
  - In the first cycle after rst_n rises, IMemReq=1.
- IF:
  - IMemReq=1.
  - On IMemAck: IRWrite=1 in that same cycle, then go to ID.
  - Otherwise stay in IF.
- ID: one cycle. If Halt=1 go to HALT; otherwise go to EX.
- EX: one cycle.
  - If MemRead or MemWrite, go to MEM.
  - Else if RegWrite, go to WB.
  - Else assert PCWrite=1 and go to IF (branch/jump-only and fence-type instructions).
- MEM:
  - DMemReq=1 until DMemAck.
  - On ack: if MemRead and RegWrite, go to WB.
  - On ack otherwise: PCWrite=1 and go to IF.
- WB: RegWriteEn=1 and PCWrite=1 for exactly one cycle, then go to IF.
- HALT: Halted=1. All request and strobe outputs are 0. Stays until reset.
- FAULT: Fault=1. Same behaviour as HALT.
- Combinational outputs: IMemReq, DMemReq, IRWrite, PCWrite and RegWriteEn are decoded from the current state and ack. They are never asserted outside the states listed above.
- An ack arriving while the matching request is low is ignored. So is an ack arriving in HALT or FAULT.
- Wait counter:
  - Clears on entry to IF or MEM and increments each unacknowledged cycle.
  - If MEM_TIMEOUT>0 and the request has gone unacknowledged for MEM_TIMEOUT cycles, the next state is FAULT.
  - An ack in the final allowed cycle wins over the timeout.
- CycleCount: increments every cycle the state is not HALT or FAULT.
- InstRet: increments on every PCWrite pulse.
- Both counters wrap modulo 2^64.

## Timing
- With zero-wait memory (ack in the first request cycle):
  - ALU op: 4 cycles (IF, ID, EX, WB).
  - Load: 5 cycles.
  - Store: 4 cycles (IF, ID, EX, MEM).
  - Branch/no-write: 3 cycles.
- Each memory wait cycle adds one cycle.
- Register-file write and PC update take effect at the clock edge ending the WB cycle (or the ending MEM/EX cycle when there is no WB).
- Counters and Stage are registered. Counter values reflect updates from the previous edge.
- Reset assertion mid-instruction aborts immediately and asynchronously: all outputs go to 0 and Stage=IF. Any partially completed memory request is abandoned; memory must tolerate a dropped request.

## Structure
- Shared package holds:
  - the state enum and its encodings (Stage values above);
  - the counter width constant (64);
  - the default timeout.
- One sub-module: wait_timer, containing the clearable wait counter and timeout compare (width from MEM_TIMEOUT). Everything else lives in stage_sequencer.

## Test plan
- ALU op, immediate acks, RegWrite=1 -> Stage 0,1,2,4,0. RegWriteEn and PCWrite both high only in the WB cycle. InstRet=1 and CycleCount=4 after 4 cycles.
- Load, DMemAck delayed 3 cycles -> DMemReq high 4 cycles, MEM lasts 4 cycles, total 8 cycles. RegWriteEn pulses once; InstRet=1.
- Store, immediate acks -> PCWrite in the MEM ack cycle; RegWriteEn never asserted; next Stage=0; 4 cycles total.
- MEM_TIMEOUT=4, IMemAck held low -> Stage=6 and Fault=1 from cycle 5. CycleCount frozen at 4. A later IMemAck has no effect.
- Halt=1 in ID -> Stage=5, Halted=1, no PCWrite, InstRet unchanged. Outputs stay at 0 for 100 cycles.
- rst_n pulsed low during MEM of a load -> outputs and counters 0 immediately. After release, IMemReq=1 and Stage=0.
